// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared state encoding and defaults for the inference controller
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_WAIT_INTR = 3'd2,
        ST_AR        = 3'd3,
        ST_R         = 3'd4,
        ST_DONE      = 3'd5
    } nn_state_t;

    localparam int          NN_NUM_PIXELS  = 784;
    localparam logic [31:0] NN_RESULT_ADDR = 32'h8;

endpackage

// File: rtl/nn_pix_skid.sv
// rtl/nn_pix_skid.sv - 2-entry beat buffer with registered outputs
module nn_pix_skid #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_out_valid;
    logic                  r_skid_valid;
    logic                  w_pop;

    assign w_pop = r_out_valid && i_tready;

    // Caller guarantees a push never arrives while both entries are held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_data   <= '0;
            r_skid_data  <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= i_tvalid;
                if (i_tvalid) r_skid_data <= i_tdata;
            end else begin
                r_out_valid <= i_tvalid;
                if (i_tvalid) r_out_data <= i_tdata;
            end
        end else if (i_tvalid) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_tdata;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_tdata;
            end
        end
    end

    assign o_tdata  = r_out_data;
    assign o_tvalid = r_out_valid;
    assign o_count  = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/nn_infer_ctrl.sv
// rtl/nn_infer_ctrl.sv - frame-buffer to network streamer with AXI-Lite result fetch
// Optional WAIT_INTR timeout enabled by defining INFER_TIMEOUT_EN.
module nn_infer_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int          DATA_WIDTH     = 16,
    parameter int          NUM_PIXELS     = NN_NUM_PIXELS,
    parameter logic [31:0] RESULT_ADDR    = NN_RESULT_ADDR,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic [9:0]            fb_rd_addr,
    output logic                  fb_rd_en,
    input  logic [7:0]            fb_rd_data,
    output logic [DATA_WIDTH-1:0] axis_in_data,
    output logic                  axis_in_data_valid,
    input  logic                  axis_in_data_ready,
    input  logic                  intr,
    output logic [31:0]           m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [7:0]            result,
    output logic                  result_valid,
    output logic                  timeout
);

    localparam int CW = $clog2(NUM_PIXELS);

    nn_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_rd_cnt;
    logic [CW-1:0]   r_beat_cnt;
    logic            r_rd_all;
    logic            r_rd_pend;
    logic            r_intr_seen;
    logic [7:0]      r_result;
    logic [1:0]      w_skid_cnt;
    logic [1:0]      w_occ;
    logic            w_pop;
    logic            w_rd_en;
    logic            w_last_beat;
    logic            w_expire;
    logic            w_unused_rdata;

    assign w_unused_rdata = ^m_axi_rdata[31:8];

    nn_pix_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk      (s_axi_aclk),
        .resetn   (s_axi_aresetn),
        .i_tdata  (DATA_WIDTH'(fb_rd_data)),
        .i_tvalid (r_rd_pend),
        .o_tdata  (axis_in_data),
        .o_tvalid (axis_in_data_valid),
        .i_tready (axis_in_data_ready),
        .o_count  (w_skid_cnt)
    );

    // A read is only issued if its data is sure to find a free slot one cycle later.
    assign w_pop       = axis_in_data_valid && axis_in_data_ready;
    assign w_occ       = w_skid_cnt + {1'b0, r_rd_pend};
    assign w_rd_en     = (r_state == ST_STREAM) && !r_rd_all &&
                         ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
    assign w_last_beat = w_pop && (r_beat_cnt == CW'(NUM_PIXELS - 1));

`ifdef INFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    assign w_expire = (r_state == ST_WAIT_INTR) && !(r_intr_seen || intr) &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            r_to_cnt  <= (r_state == ST_WAIT_INTR) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign timeout = r_timeout;
`else
    localparam int unused_to_cycles = TIMEOUT_CYCLES;
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_state_nxt = ST_STREAM;
            ST_STREAM:    if (w_last_beat) w_state_nxt = ST_WAIT_INTR;
            ST_WAIT_INTR: begin
                if (r_intr_seen || intr) w_state_nxt = ST_AR;
                else if (w_expire)       w_state_nxt = ST_DONE;
            end
            ST_AR:        if (m_axi_arready) w_state_nxt = ST_R;
            ST_R:         if (m_axi_rvalid) w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_rd_cnt    <= '0;
            r_beat_cnt  <= '0;
            r_rd_all    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_intr_seen <= 1'b0;
            r_result    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_rd_en;
            if ((r_state == ST_IDLE) && start) begin
                r_rd_cnt    <= '0;
                r_beat_cnt  <= '0;
                r_rd_all    <= 1'b0;
                r_intr_seen <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    if (r_rd_cnt == CW'(NUM_PIXELS - 1)) r_rd_all <= 1'b1;
                    else                                 r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_pop && !w_last_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
                if (intr && ((r_state == ST_STREAM) || (r_state == ST_WAIT_INTR)))
                    r_intr_seen <= 1'b1;
            end
            if ((r_state == ST_R) && m_axi_rvalid) r_result <= m_axi_rdata[7:0];
            else if (w_expire)                     r_result <= 8'hFF;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign fb_rd_en      = w_rd_en;
    assign fb_rd_addr    = 10'(r_rd_cnt);
    assign m_axi_arvalid = (r_state == ST_AR);
    assign m_axi_araddr  = (r_state == ST_AR) ? RESULT_ADDR : 32'h0;
    assign m_axi_rready  = (r_state == ST_R);
    assign result_valid  = (r_state == ST_DONE);
    assign result        = r_result;

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb/tb_nn_infer_ctrl.sv - scoreboard bench for nn_infer_ctrl
module tb_nn_infer_ctrl;

    localparam int DW = 16;
    localparam int NP = 784;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          s_axi_aresetn;
    logic          start;
    logic          busy;
    logic [9:0]    fb_rd_addr;
    logic          fb_rd_en;
    logic [7:0]    fb_rd_data;
    logic [DW-1:0] axis_in_data;
    logic          axis_in_data_valid;
    logic          axis_in_data_ready;
    logic          intr;
    logic [31:0]   m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [31:0]   m_axi_rdata;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [7:0]    result;
    logic          result_valid;
    logic          timeout;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int            rdy_mode = 0;
    logic [31:0]   rdata_val = 32'h7;
    int            ar_wait = 0;

    int            cyc = 0;
    int            beat_idx = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    int            ar_seen = 0;
    int            rv_cnt = 0;
    int            rv_cyc = 0;
    int            to_cnt = 0;
    int            to_cyc = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [DW-1:0] pd = '0;

    always #5 clk = ~clk;

    nn_infer_ctrl #(
        .DATA_WIDTH(DW), .NUM_PIXELS(NP), .RESULT_ADDR(32'h8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn), .start(start), .busy(busy),
        .fb_rd_addr(fb_rd_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
        .axis_in_data(axis_in_data), .axis_in_data_valid(axis_in_data_valid),
        .axis_in_data_ready(axis_in_data_ready), .intr(intr),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .result(result), .result_valid(result_valid), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame buffer: fb[i] = i[7:0], one-cycle read latency.
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb_rd_addr[7:0];

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) axis_in_data_ready = ($urandom_range(0, 99) < 30);
        else               axis_in_data_ready = 1'b1;
        if (m_axi_arvalid) begin
            m_axi_arready = (ar_wait == 2);
            ar_wait++;
        end else begin
            m_axi_arready = 1'b0;
            ar_wait = 0;
        end
        if (m_axi_rready) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rdata_val;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = 32'h0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (s_axi_aresetn) begin
            if (pv && !pr) begin
                chk("hold_valid", {31'b0, axis_in_data_valid}, 32'd1);
                chk("hold_data", {16'b0, axis_in_data}, {16'b0, pd});
            end
            if (axis_in_data_valid && axis_in_data_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
                else                   chk("beat_data", {16'b0, axis_in_data}, {16'b0, exp_q.pop_front()});
                if (beat_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_idx++;
            end
            if (m_axi_arvalid) begin
                ar_seen++;
                chk("araddr", m_axi_araddr, 32'h8);
            end
            if (result_valid) begin rv_cnt++; rv_cyc = cyc; end
            if (timeout)      begin to_cnt++; to_cyc = cyc; end
            pv = axis_in_data_valid;
            pr = axis_in_data_ready;
            pd = axis_in_data;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_idx = 0; ar_seen = 0; rv_cnt = 0; to_cnt = 0;
        exp_q.delete();
    endtask

    task automatic push_frame();
        for (int i = 0; i < NP; i++) exp_q.push_back(DW'(i & 255));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_intr();
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beat_idx < n && k < budget) begin tick(1); k++; end
        chk("beats_reached", {31'b0, beat_idx >= n}, 32'd1);
    endtask

    task automatic wait_result(input int budget);
        int k = 0;
        while (rv_cnt == 0 && k < budget) begin tick(1); k++; end
        chk("result_seen", {31'b0, rv_cnt > 0}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"},  {31'b0, busy}, 32'd0);
        chk({pfx, "_rden"},  {31'b0, fb_rd_en}, 32'd0);
        chk({pfx, "_valid"}, {31'b0, axis_in_data_valid}, 32'd0);
        chk({pfx, "_data"},  {16'b0, axis_in_data}, 32'd0);
        chk({pfx, "_arv"},   {31'b0, m_axi_arvalid}, 32'd0);
        chk({pfx, "_rrdy"},  {31'b0, m_axi_rready}, 32'd0);
        chk({pfx, "_rv"},    {31'b0, result_valid}, 32'd0);
        chk({pfx, "_to"},    {31'b0, timeout}, 32'd0);
        chk({pfx, "_res"},   {24'b0, result}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expired expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_aresetn = 1'b0; start = 1'b0; intr = 1'b0;
        axis_in_data_ready = 1'b1; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;
        tick(3);
        check_reset_outputs("rst");
        s_axi_aresetn = 1'b1;
        tick(1);

        // Full-rate stream, then delayed AXI read returning 7.
        clear_mon(); rdata_val = 32'h7;
        push_frame();
        pulse_start();
        tick(2);
        chk("first_valid_lat", {31'b0, axis_in_data_valid}, 32'd1);
        wait_beats(NP, 3000);
        chk("consecutive", last_cyc - first_cyc, NP - 1);
        chk("valid_drop", {31'b0, axis_in_data_valid}, 32'd0);
        chk("busy_wait", {31'b0, busy}, 32'd1);
        chk("q_empty_a", exp_q.size(), 32'd0);
        tick(2);
        pulse_intr();
        wait_result(50);
        chk("ar_cycles", ar_seen, 32'd3);
        chk("result_a", {24'b0, result}, 32'h7);
        chk("busy_after_a", {31'b0, busy}, 32'd0);
        tick(3);
        chk("rv_pulses_a", rv_cnt, 32'd1);

        // 30% ready with intr during beat 500.
        clear_mon(); rdata_val = 32'hABCD_EF5A; rdy_mode = 1;
        push_frame();
        pulse_start();
        wait_beats(500, 6000);
        pulse_intr();
        wait_beats(NP, 8000);
        chk("q_empty_b", exp_q.size(), 32'd0);
        tick(2);
        chk("ar_no_intr", {31'b0, ar_seen > 0}, 32'd1);
        wait_result(50);
        chk("result_b", {24'b0, result}, 32'h5A);
        rdy_mode = 0;
        tick(2);

        // start during WAIT_INTR is ignored.
        clear_mon(); rdata_val = 32'h3;
        push_frame();
        pulse_start();
        wait_beats(NP, 3000);
        tick(2);
        pulse_start();
        tick(3);
        chk("ign_busy", {31'b0, busy}, 32'd1);
        chk("ign_rden", {31'b0, fb_rd_en}, 32'd0);
        chk("ign_valid", {31'b0, axis_in_data_valid}, 32'd0);
        chk("ign_beats", beat_idx, NP);
        chk("ign_ar", ar_seen, 32'd0);
        pulse_intr();
        wait_result(50);
        chk("result_c", {24'b0, result}, 32'h3);
        tick(2);

        // Reset at beat 300, then a clean restart from pixel 0.
        clear_mon();
        push_frame();
        pulse_start();
        wait_beats(300, 3000);
        s_axi_aresetn = 1'b0;
        tick(1);
        check_reset_outputs("mid");
        s_axi_aresetn = 1'b1;
        clear_mon();
        tick(1);
        push_frame();
        pulse_start();
        wait_beats(NP, 3000);
        chk("q_empty_d", exp_q.size(), 32'd0);
        pulse_intr();
        wait_result(50);
        chk("result_d", {24'b0, result}, 32'h3);
        tick(2);

`ifdef INFER_TIMEOUT_EN
        clear_mon();
        push_frame();
        pulse_start();
        wait_beats(NP, 3000);
        begin
            int k = 0;
            while (to_cnt == 0 && k < 200) begin tick(1); k++; end
        end
        chk("to_seen", to_cnt, 32'd1);
        chk("to_latency", to_cyc - last_cyc, 32'd51);
        chk("to_rv_same", rv_cyc, to_cyc);
        chk("to_result", {24'b0, result}, 32'hFF);
        chk("to_no_ar", ar_seen, 32'd0);
        tick(3);
        chk("to_idle", {31'b0, busy}, 32'd0);
`else
        chk("no_timeout", to_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
